// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: register index width,
// the x0 index, and the operand-source encoding exposed for debug.
package operand_fetch_pkg;

   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] X0 = '0;

   typedef enum logic [1:0] {
      SEL_ZERO   = 2'd0,
      SEL_RF     = 2'd1,
      SEL_BYPASS = 2'd2
   } opsel_e;

   // x0 always reads zero; a same-cycle writeback beats the stale regfile read.
   function automatic opsel_e op_select(input logic [REG_IDX_W-1:0] rs,
                                        input logic                 wb_en,
                                        input logic [REG_IDX_W-1:0] wb_addr);
      if (rs == X0)
         return SEL_ZERO;
      else if (wb_en && (wb_addr == rs))
         return SEL_BYPASS;
      else
         return SEL_RF;
   endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with
// busy lookups that already account for a writeback landing this cycle.
module of_scoreboard
   import operand_fetch_pkg::*;
#(
   parameter int REGFILE_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 set_en,
   input  logic [REG_IDX_W-1:0] set_idx,
   input  logic                 clr_en,
   input  logic [REG_IDX_W-1:0] clr_idx,
   input  logic [REG_IDX_W-1:0] q1_idx,
   input  logic [REG_IDX_W-1:0] q2_idx,
   input  logic [REG_IDX_W-1:0] q3_idx,
   output logic                 q1_busy,
   output logic                 q2_busy,
   output logic                 q3_busy
);

   logic [REGFILE_SIZE-1:0] sb_q;
   logic [REGFILE_SIZE-1:0] sb_d;

   function automatic logic lookup(input logic [REG_IDX_W-1:0] idx);
      return (idx != X0) && sb_q[idx] && !(clr_en && (clr_idx == idx));
   endfunction

   assign q1_busy = lookup(q1_idx);
   assign q2_busy = lookup(q2_idx);
   assign q3_busy = lookup(q3_idx);

   // A set and a clear of the same register in one cycle leaves it busy.
   always_comb begin
      sb_d = sb_q;
      for (int i = 0; i < REGFILE_SIZE; i++) begin
         if (clr_en && (clr_idx == i[REG_IDX_W-1:0]))
            sb_d[i] = 1'b0;
         if (set_en && (set_idx == i[REG_IDX_W-1:0]))
            sb_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sb_q <= '0;
      else if (flush)
         sb_q <= '0;
      else
         sb_q <= sb_d;
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: regfile read address drive, writeback bypass,
// scoreboard hazard stall, and a registered valid/ready output to execute.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int REGFILE_SIZE = 32,
   parameter int WORD_SIZE    = 32,
   parameter int TAG_W        = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [4:0]           in_rd,
   input  logic                 in_rd_we,
   input  logic [TAG_W-1:0]     in_tag,
   output logic [31:0]          rf_raddr1,
   output logic [31:0]          rf_raddr2,
   input  logic [WORD_SIZE-1:0] rf_rdata1,
   input  logic [WORD_SIZE-1:0] rf_rdata2,
   input  logic                 wb_en,
   input  logic [4:0]           wb_addr,
   input  logic [WORD_SIZE-1:0] wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_op1,
   output logic [WORD_SIZE-1:0] out_op2,
   output logic [4:0]           out_rd,
   output logic                 out_rd_we,
   output logic [TAG_W-1:0]     out_tag
);

   opsel_e               sel1;
   opsel_e               sel2;
   logic [WORD_SIZE-1:0] op1_p0;
   logic [WORD_SIZE-1:0] op2_p0;
   logic                 busy1;
   logic                 busy2;
   logic                 busy_rd;
   logic                 hazard;
   logic                 accept;
   logic                 rd_tracked;

   logic                 vld_p1;
   logic [WORD_SIZE-1:0] op1_p1;
   logic [WORD_SIZE-1:0] op2_p1;
   logic [4:0]           rd_p1;
   logic                 rd_we_p1;
   logic [TAG_W-1:0]     tag_p1;

   function automatic logic [WORD_SIZE-1:0] pick(input opsel_e sel,
                                                 input logic [WORD_SIZE-1:0] rf);
      case (sel)
         SEL_ZERO:   return '0;
         SEL_BYPASS: return wb_data;
         default:    return rf;
      endcase
   endfunction

   assign rf_raddr1 = {{(32-REG_IDX_W){1'b0}}, in_rs1};
   assign rf_raddr2 = {{(32-REG_IDX_W){1'b0}}, in_rs2};

   // Stage p0: operand select and hazard check on the incoming instruction
   assign sel1   = op_select(in_rs1, wb_en, wb_addr);
   assign sel2   = op_select(in_rs2, wb_en, wb_addr);
   assign op1_p0 = pick(sel1, rf_rdata1);
   assign op2_p0 = pick(sel2, rf_rdata2);

   assign rd_tracked = in_rd_we && (in_rd != X0);
   assign hazard     = busy1 || busy2 || (rd_tracked && busy_rd);
   assign in_ready   = !flush && !hazard && (!vld_p1 || out_ready);
   assign accept     = in_valid && in_ready;

   of_scoreboard #(
      .REGFILE_SIZE (REGFILE_SIZE)
   ) u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .set_en  (accept && rd_tracked),
      .set_idx (in_rd),
      .clr_en  (wb_en && (wb_addr != X0)),
      .clr_idx (wb_addr),
      .q1_idx  (in_rs1),
      .q2_idx  (in_rs2),
      .q3_idx  (in_rd),
      .q1_busy (busy1),
      .q2_busy (busy2),
      .q3_busy (busy_rd)
   );

   // Stage p1: output register toward execute
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         op1_p1   <= '0;
         op2_p1   <= '0;
         rd_p1    <= '0;
         rd_we_p1 <= 1'b0;
         tag_p1   <= '0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         op1_p1   <= op1_p0;
         op2_p1   <= op2_p0;
         rd_p1    <= in_rd;
         rd_we_p1 <= in_rd_we;
         tag_p1   <= in_tag;
      end else if (vld_p1 && out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign out_op1   = op1_p1;
   assign out_op2   = op2_p1;
   assign out_rd    = rd_p1;
   assign out_rd_we = rd_we_p1;
   assign out_tag   = tag_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table, directed hazard/backpressure/flush/reset
// sequences, then randomized traffic against a behavioural model.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_rd_we;
   logic [31:0] in_tag;
   logic [31:0] rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_op1, out_op2;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [31:0] out_tag;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   operand_fetch #(.REGFILE_SIZE(32), .WORD_SIZE(32), .TAG_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_tag(in_tag),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
      .out_rd_we(out_rd_we), .out_tag(out_tag)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0;
      in_tag = 0; rf_rdata1 = 0; rf_rdata2 = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
      out_ready = 1;
   endtask

   task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic we, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] tag);
      in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
      rf_rdata1 = d1; rf_rdata2 = d2; in_tag = tag;
   endtask

   // inputs change at posedge+1, comb checks at posedge+5, registered checks at posedge+1
   task automatic mid();
      #4;
   endtask
   task automatic tick();
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [4:0]  rs1, rs2;
      logic [31:0] d1, d2;
      logic        wbe;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic [31:0] e1, e2;
   } vec_t;

   vec_t tbl[6];

   // behavioural reference state
   bit          m_busy[32];
   bit          m_vld;
   logic [31:0] m_op1, m_op2, m_tag;
   logic [4:0]  m_rd;
   logic        m_we;

   function automatic bit m_isbusy(input logic [4:0] r);
      return (r != 0) && m_busy[r] && !(wb_en && wb_addr == r);
   endfunction

   function automatic bit m_ready();
      bit hz;
      hz = m_isbusy(in_rs1) || m_isbusy(in_rs2) || (in_rd_we && in_rd != 0 && m_isbusy(in_rd));
      return !flush && !hz && (!m_vld || out_ready);
   endfunction

   function automatic logic [31:0] m_operand(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 0) return 32'h0;
      if (wb_en && wb_addr == rs) return wb_data;
      return rf;
   endfunction

   task automatic m_clock(input bit acc);
      if (flush) begin
         m_vld = 0;
         foreach (m_busy[i]) m_busy[i] = 0;
      end else begin
         if (acc) begin
            m_vld = 1; m_op1 = m_operand(in_rs1, rf_rdata1); m_op2 = m_operand(in_rs2, rf_rdata2);
            m_rd = in_rd; m_we = in_rd_we; m_tag = in_tag;
         end else if (m_vld && out_ready) begin
            m_vld = 0;
         end
         if (wb_en && wb_addr != 0) m_busy[wb_addr] = 0;
         if (acc && in_rd_we && in_rd != 0) m_busy[in_rd] = 1;
      end
   endtask

   initial begin
      logic [31:0] prev_op1;
      bit          exp_rdy;

      tbl[0] = '{5'd3,  5'd4, 32'h11,    32'h22, 1'b0, 5'd0, 32'h0,    32'h11,   32'h22};
      tbl[1] = '{5'd0,  5'd4, 32'hDEAD,  32'h22, 1'b1, 5'd0, 32'hBEEF, 32'h0,    32'h22};
      tbl[2] = '{5'd6,  5'd6, 32'h1,     32'h2,  1'b1, 5'd6, 32'h66,   32'h66,   32'h66};
      tbl[3] = '{5'd5,  5'd0, 32'hAA,    32'hBB, 1'b1, 5'd9, 32'h99,   32'hAA,   32'h0};
      tbl[4] = '{5'd0,  5'd0, 32'h5,     32'h6,  1'b0, 5'd0, 32'h0,    32'h0,    32'h0};
      tbl[5] = '{5'd31, 5'd1, 32'hCAFE,  32'h7,  1'b1, 5'd1, 32'h1234, 32'hCAFE, 32'h1234};

      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_op1", out_op1, 0);
      chk("reset_out_op2", out_op2, 0);
      chk("reset_out_rd", out_rd, 0);
      chk("reset_out_rd_we", out_rd_we, 0);
      chk("reset_out_tag", out_tag, 0);
      rst_n = 1;

      // table: independent, hazard-free accepts with bypass / x0 cases
      for (int i = 0; i < 6; i++) begin
         instr(tbl[i].rs1, tbl[i].rs2, 5'd0, 1'b0, tbl[i].d1, tbl[i].d2, 32'h100 + i);
         wb_en = tbl[i].wbe; wb_addr = tbl[i].wba; wb_data = tbl[i].wbd;
         mid();
         chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
         chk($sformatf("tbl%0d_raddr1", i), rf_raddr1, {27'b0, tbl[i].rs1});
         tick();
         chk($sformatf("tbl%0d_out_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d_op1", i), out_op1, tbl[i].e1);
         chk($sformatf("tbl%0d_op2", i), out_op2, tbl[i].e2);
         chk($sformatf("tbl%0d_tag", i), out_tag, 32'h100 + i);
      end
      idle_inputs(); tick();
      chk("drain_out_valid", out_valid, 0);

      // RAW stall on x5 released by writeback with bypass
      instr(5'd1, 5'd2, 5'd5, 1'b1, 32'h1, 32'h2, 32'hA1);
      tick();
      chk("raw_i1_rd", out_rd, 5);
      chk("raw_i1_we", out_rd_we, 1);
      instr(5'd5, 5'd2, 5'd0, 1'b0, 32'h0, 32'h2, 32'hA2);
      for (int c = 0; c < 2; c++) begin
         mid(); chk("raw_stall_in_ready", in_ready, 0); tick();
      end
      chk("raw_stall_out_valid", out_valid, 0);
      wb_en = 1; wb_addr = 5; wb_data = 32'h55;
      mid(); chk("raw_release_in_ready", in_ready, 1);
      tick();
      chk("raw_bypass_op1", out_op1, 32'h55);
      chk("raw_bypass_valid", out_valid, 1);

      // backpressure: outputs hold for 3 cycles, then drain and accept together
      wb_en = 0; out_ready = 0;
      instr(5'd1, 5'd2, 5'd0, 1'b0, 32'h77, 32'h88, 32'hA3);
      for (int c = 0; c < 3; c++) begin
         mid();
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_op1_stable", out_op1, 32'h55);
         tick();
      end
      out_ready = 1;
      mid(); chk("bp_release_in_ready", in_ready, 1);
      tick();
      chk("bp_next_op1", out_op1, 32'h77);
      chk("bp_next_tag", out_tag, 32'hA3);

      // set and clear of x7 in the same cycle: set wins
      instr(5'd1, 5'd2, 5'd7, 1'b1, 32'h3, 32'h4, 32'hA4);
      wb_en = 1; wb_addr = 7; wb_data = 32'h70;
      mid(); chk("sc_in_ready", in_ready, 1);
      tick();
      wb_en = 0;
      instr(5'd7, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'hA5);
      mid(); chk("sc_x7_stall", in_ready, 0);
      tick();

      // flush clears scoreboard and output valid
      instr(5'd1, 5'd2, 5'd9, 1'b1, 32'h3, 32'h4, 32'hA6);
      mid(); chk("fl_set9_ready", in_ready, 1);
      tick();
      chk("fl_pre_valid", out_valid, 1);
      in_valid = 1; flush = 1;
      mid(); chk("fl_in_ready", in_ready, 0);
      tick();
      flush = 0;
      chk("fl_out_valid", out_valid, 0);
      instr(5'd9, 5'd7, 5'd0, 1'b0, 32'h9, 32'h7, 32'hA7);
      mid(); chk("fl_x9_ready", in_ready, 1);
      tick();
      chk("fl_x9_valid", out_valid, 1);
      chk("fl_x9_op1", out_op1, 32'h9);

      // asynchronous reset during a stall
      instr(5'd1, 5'd2, 5'd10, 1'b1, 32'h3, 32'h4, 32'hA8);
      tick();
      instr(5'd10, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'hA9);
      mid(); chk("rst_stall_ready", in_ready, 0);
      #1 rst_n = 0;
      #1;
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_op1", out_op1, 0);
      chk("rst_async_ready", in_ready, 1);
      #1 rst_n = 1;
      idle_inputs();
      tick();

      // randomized traffic against the behavioural model
      m_vld = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_we = 0; m_tag = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(9) < 7);
         in_rs1    = 5'($urandom_range(7));
         in_rs2    = 5'($urandom_range(7));
         in_rd     = 5'($urandom_range(7));
         in_rd_we  = $urandom_range(1);
         in_tag    = $urandom;
         rf_rdata1 = $urandom;
         rf_rdata2 = $urandom;
         wb_en     = ($urandom_range(9) < 4);
         wb_addr   = 5'($urandom_range(7));
         wb_data   = $urandom;
         out_ready = ($urandom_range(9) < 7);
         flush     = ($urandom_range(99) < 3);
         mid();
         exp_rdy = m_ready();
         chk("rnd_in_ready", in_ready, exp_rdy);
         m_clock(in_valid && exp_rdy);
         tick();
         chk("rnd_out_valid", out_valid, m_vld);
         if (m_vld) begin
            chk("rnd_op1", out_op1, m_op1);
            chk("rnd_op2", out_op2, m_op2);
            chk("rnd_rd", {m_we, out_rd}, {m_we, m_rd});
            chk("rnd_rd_we", out_rd_we, m_we);
            chk("rnd_tag", out_tag, m_tag);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
